// File: rtl/bitmask_set_bit_iterator_pkg.sv
// Shared types and helpers for the set-bit iterator.
// Holds the FSM encoding and the index-width function.
package bitmask_set_bit_iterator_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        ITERATE = 1'b1
    } state_e;

    // ceil(log2(v)), never below 1 so a 1-bit word still has an index bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bitmask_set_bit_iterator_if.sv
// Handshake bundle for the set-bit iterator: input word channel
// (in_valid/in_ready/word_in) and one-hot beat channel (out_*).
interface bitmask_set_bit_iterator_if
    import bitmask_set_bit_iterator_pkg::*;
#(
    parameter int WORD_WIDTH = 8
);
    localparam int INDEX_WIDTH = clog2_min1(WORD_WIDTH);

    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_WIDTH-1:0]  word_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_WIDTH-1:0]  out_onehot;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_last;

    // master: word producer and beat consumer
    modport master (
        output in_valid, word_in, out_ready,
        input  in_ready, out_valid, out_onehot, out_index, out_last
    );

    // slave: the iterator itself
    modport slave (
        input  in_valid, word_in, out_ready,
        output in_ready, out_valid, out_onehot, out_index, out_last
    );
endinterface

// File: rtl/bitmask_isolate_rightmost_1_bit.sv
// Isolates the rightmost set bit of a word (word & -word).
// Ports: word_in (mask), onehot_out (lowest set bit only, 0 if none).
module bitmask_isolate_rightmost_1_bit #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic [WORD_WIDTH-1:0] onehot_out
);
    assign onehot_out = word_in & (~word_in + WORD_WIDTH'(1));
endmodule

// File: rtl/bitmask_set_bit_iterator.sv
// Emits each set bit of an accepted word as a one-hot beat, LSB first.
// Ports: clock, reset_n (async, active-low), bus (slave handshake bundle).
module bitmask_set_bit_iterator
    import bitmask_set_bit_iterator_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    bitmask_set_bit_iterator_if.slave     bus
);
    localparam int INDEX_WIDTH = clog2_min1(WORD_WIDTH);

    state_e                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  remaining_q, remaining_d;
    logic [WORD_WIDTH-1:0]  onehot;
    logic [WORD_WIDTH-1:0]  rest;
    logic [INDEX_WIDTH-1:0] index;
    logic                   out_valid;
    logic                   out_last;
    logic                   in_ready;
    logic                   accept;
    logic                   xfer;

    bitmask_isolate_rightmost_1_bit #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_isolate (
        .word_in    (remaining_q),
        .onehot_out (onehot)
    );

    // remaining with its rightmost 1 cleared
    assign rest = remaining_q & (remaining_q - WORD_WIDTH'(1));

    // one-hot to binary: each index bit ORs the positions that have it set
    always_comb begin
        index = '0;
        for (int b = 0; b < INDEX_WIDTH; b++) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
                if (((i >> b) & 1) == 1) index[b] = index[b] | onehot[i];
            end
        end
    end

    assign out_valid = (state_q == ITERATE);
    assign out_last  = out_valid & (rest == '0);
    // out_ready feeds in_ready so a new word can land on the last beat
    assign in_ready  = (state_q == IDLE) | (out_valid & bus.out_ready & out_last);
    assign accept    = bus.in_valid & in_ready;
    assign xfer      = out_valid & bus.out_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_onehot = onehot;
    assign bus.out_index  = index;
    assign bus.out_last   = out_last;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.word_in != '0) begin
                    remaining_d = bus.word_in;
                    state_d     = ITERATE;
                end
            end
            ITERATE: begin
                if (xfer) begin
                    remaining_d = rest;
                    if (out_last) state_d = IDLE;
                end
                // accept only happens here alongside the last transfer
                if (accept && bus.word_in != '0) begin
                    remaining_d = bus.word_in;
                    state_d     = ITERATE;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_bitmask_set_bit_iterator.sv
// Directed self-checking bench for bitmask_set_bit_iterator.
// Drives and samples on the falling edge; the DUT registers on the rising edge.
module tb_bitmask_set_bit_iterator;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    bitmask_set_bit_iterator_if #(.WORD_WIDTH(8)) bus8 ();
    bitmask_set_bit_iterator_if #(.WORD_WIDTH(1)) bus1 ();

    bitmask_set_bit_iterator #(.WORD_WIDTH(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    bitmask_set_bit_iterator #(.WORD_WIDTH(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // wait for the next falling edge, apply inputs, let outputs settle
    task automatic step(input logic iv, input logic [7:0] w, input logic ordy);
        @(negedge clock);
        bus8.in_valid  = iv;
        bus8.word_in   = w;
        bus8.out_ready = ordy;
        #1;
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.word_in   = '0;
        bus8.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.word_in   = '0;
        bus1.out_ready = 1'b1;
        #12;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus8.in_ready);
        end
        checks++;
        if ({bus8.out_valid, bus8.out_last} !== 2'b00) begin
            errors++; $display("FAIL reset_valid_last got %b%b want 00", bus8.out_valid, bus8.out_last);
        end
        checks++;
        if ({bus8.out_onehot, bus8.out_index} !== 11'd0) begin
            errors++; $display("FAIL reset_onehot_idx got %b/%0d want 0/0", bus8.out_onehot, bus8.out_index);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_sparse;
        logic [7:0] eoh [3] = '{8'h08, 8'h20, 8'h80};
        logic [2:0] eix [3] = '{3'd3, 3'd5, 3'd7};
        step(1'b1, 8'hA8, 1'b1);
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL sparse_accept rdy %b vld %b want 1 0", bus8.in_ready, bus8.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_onehot !== eoh[k] ||
                bus8.out_index !== eix[k] || bus8.out_last !== (k == 2) ||
                bus8.in_ready !== (k == 2)) begin
                errors++;
                $display("FAIL sparse_beat%0d got v%b oh %b idx %0d last %b rdy %b want oh %b idx %0d",
                         k, bus8.out_valid, bus8.out_onehot, bus8.out_index,
                         bus8.out_last, bus8.in_ready, eoh[k], eix[k]);
            end
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL sparse_done out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_zero_word;
        step(1'b1, 8'h00, 1'b1);
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL zero_accept in_ready %b want 1", bus8.in_ready);
        end
        step(1'b1, 8'h04, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL zero_nobeat vld %b rdy %b want 0 1", bus8.out_valid, bus8.in_ready);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_onehot !== 8'h04 ||
            bus8.out_index !== 3'd2 || bus8.out_last !== 1'b1) begin
            errors++;
            $display("FAIL zero_next got v%b oh %b idx %0d last %b want 1 00000100 2 1",
                     bus8.out_valid, bus8.out_onehot, bus8.out_index, bus8.out_last);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_done out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_backpressure;
        step(1'b1, 8'h06, 1'b0);
        for (int k = 0; k < 3; k++) begin
            // a word offered while busy must be ignored
            step(1'b1, 8'h55, 1'b0);
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_onehot !== 8'h02 ||
                bus8.out_index !== 3'd1 || bus8.out_last !== 1'b0 ||
                bus8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v%b oh %b idx %0d last %b rdy %b want 1 00000010 1 0 0",
                         k, bus8.out_valid, bus8.out_onehot, bus8.out_index,
                         bus8.out_last, bus8.in_ready);
            end
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_index !== 3'd1 || bus8.out_last !== 1'b0) begin
            errors++; $display("FAIL bp_first idx %0d last %b want 1 0", bus8.out_index, bus8.out_last);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_onehot !== 8'h04 || bus8.out_index !== 3'd2 || bus8.out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_second oh %b idx %0d last %b want 00000100 2 1",
                     bus8.out_onehot, bus8.out_index, bus8.out_last);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_ignored out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 8'h81, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_index !== 3'd0 || bus8.out_last !== 1'b0 || bus8.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first idx %0d last %b rdy %b want 0 0 0",
                     bus8.out_index, bus8.out_last, bus8.in_ready);
        end
        step(1'b1, 8'h01, 1'b1);
        checks++;
        if (bus8.out_index !== 3'd7 || bus8.out_last !== 1'b1 || bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last idx %0d last %b rdy %b want 7 1 1",
                     bus8.out_index, bus8.out_last, bus8.in_ready);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_onehot !== 8'h01 ||
            bus8.out_index !== 3'd0 || bus8.out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_nobubble got v%b oh %b idx %0d last %b want 1 00000001 0 1",
                     bus8.out_valid, bus8.out_onehot, bus8.out_index, bus8.out_last);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_done out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_all_ones;
        logic [7:0] one;
        one = 8'h01;
        step(1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_onehot !== (one << k) ||
                bus8.out_index !== 3'(k) || bus8.out_last !== (k == 7)) begin
                errors++;
                $display("FAIL ones_beat%0d got v%b oh %b idx %0d last %b",
                         k, bus8.out_valid, bus8.out_onehot, bus8.out_index, bus8.out_last);
            end
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL ones_done out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_width1;
        @(negedge clock);
        bus1.in_valid = 1'b1;
        bus1.word_in  = 1'b1;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL w1_idle rdy %b vld %b want 1 0", bus1.in_ready, bus1.out_valid);
        end
        @(negedge clock);
        bus1.in_valid = 1'b0;
        bus1.word_in  = 1'b0;
        #1;
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_onehot !== 1'b1 ||
            bus1.out_index !== 1'b0 || bus1.out_last !== 1'b1) begin
            errors++;
            $display("FAIL w1_beat got v%b oh %b idx %0d last %b want 1 1 0 1",
                     bus1.out_valid, bus1.out_onehot, bus1.out_index, bus1.out_last);
        end
        @(negedge clock);
        #1;
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL w1_done out_valid %b want 0", bus1.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 8'hF0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus8.out_index !== 3'd4 || bus8.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_first idx %0d vld %b want 4 1", bus8.out_index, bus8.out_valid);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus8.out_index !== 3'd5 || bus8.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_second idx %0d vld %b want 5 1", bus8.out_index, bus8.out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_async vld %b rdy %b last %b want 0 1 0",
                     bus8.out_valid, bus8.in_ready, bus8.out_last);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_residual%0d vld %b rdy %b want 0 1",
                         k, bus8.out_valid, bus8.in_ready);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sparse();
        test_zero_word();
        test_backpressure();
        test_back_to_back();
        test_all_ones();
        test_width1();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
